// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: valid/ready word handshake into the UART word transmitter
interface uart_word_tx_if;
    logic [15:0] data;
    logic        data_valid;
    logic        ready;
    modport master (output data, output data_valid, input ready);
    modport slave (input data, input data_valid, output ready);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends {tag,payload} words as two 8N1 UART frames, high byte first
module uart_word_tx #(
    parameter int CLK_HZ        = 100000000,
    parameter int BAUD          = 115200,
    parameter int DROP_ZERO_TAG = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_word_tx_if.slave bus,
    output logic          tx,
    output logic          busy,
    output logic          word_done
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_sel_q, byte_sel_d;
    logic [15:0]   word_q, word_d;
    logic          tx_q, tx_d, busy_q, busy_d, ready_q, ready_d, done_q, done_d;
    logic          last, skip;
    logic [7:0]    byte_d;
    assign last = cnt_q == CW'(DIV - 1);
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        word_d     = word_q;
        case (state_q)
            IDLE: if (ready_q && bus.data_valid) begin
                word_d     = bus.data;
                byte_sel_d = 1'b0;
                bit_d      = 3'd0;
                state_d    = START;
            end
            START: state_d = (DROP_ZERO_TAG != 0 && word_q[15:12] == 4'h0) ? DONE : last ? DATA : START;
            DATA: if (last) begin
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (last) begin
                byte_sel_d = ~byte_sel_q;
                state_d    = byte_sel_q ? DONE : START;
            end
            default: state_d = IDLE;
        endcase
        cnt_d   = (last || state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
        // outputs are registered, so they are decoded from the state being entered
        byte_d  = byte_sel_d ? word_d[7:0] : word_d[15:8];
        skip    = DROP_ZERO_TAG != 0 && word_d[15:12] == 4'h0;
        tx_d    = state_d == DATA ? byte_d[bit_d] : !(state_d == START && !skip);
        busy_d  = !skip && (state_d == START || state_d == DATA || state_d == STOP);
        ready_d = state_d == IDLE;
        done_d  = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            byte_sel_q <= 1'b0;
            word_q     <= 16'h0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign word_done = done_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench with a waveform model, a UART receiver model and literal pins
module tb_uart_word_tx;
    localparam int DIV = 10;
    typedef struct packed {logic tx; logic ready; logic busy; logic done; logic bx;} exp_t;
    localparam exp_t IDLE_E = 5'b11000;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data_a [2];
    logic        dv_a [2];
    logic        rdy_a [2];
    logic        tx_a [2];
    logic        busy_a [2];
    logic        done_a [2];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        cur [2];
    exp_t        expq [2][$];
    logic        rx_act [2];
    int          rx_t [2];
    logic [7:0]  rx_sh [2];
    logic [7:0]  rxq [2][$];
    logic        bitsq [$];
    int          fall_t [$], done_t [$], acc_t [$];
    logic        tx_prev = 1'b1;
    logic        in_word = 1'b0;
    int          tag;
    logic        adv;

    uart_word_tx_if bus0 ();
    uart_word_tx_if bus1 ();
    assign bus0.data       = data_a[0];
    assign bus0.data_valid = dv_a[0];
    assign rdy_a[0]        = bus0.ready;
    assign bus1.data       = data_a[1];
    assign bus1.data_valid = dv_a[1];
    assign rdy_a[1]        = bus1.ready;

    uart_word_tx #(.CLK_HZ(1000), .BAUD(100), .DROP_ZERO_TAG(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus0), .tx(tx_a[0]), .busy(busy_a[0]), .word_done(done_a[0]));
    uart_word_tx #(.CLK_HZ(1000), .BAUD(100), .DROP_ZERO_TAG(0)) u_nodrop (
        .clk(clk), .rst(rst), .bus(bus1), .tx(tx_a[1]), .busy(busy_a[1]), .word_done(done_a[1]));

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(logic t, logic r, logic b, logic dn, logic x);
        return {t, r, b, dn, x};
    endfunction

    // A word becomes 20 bit periods of line levels followed by one done cycle;
    // instance 0 drops zero tags: one quiet cycle, then done.
    task automatic build(int d, logic [15:0] w);
        logic [19:0] frame;
        if (d == 0 && w[15:12] == 4'h0) begin
            expq[d].push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            frame = {1'b1, w[7:0], 1'b0, 1'b1, w[15:8], 1'b0};
            for (int i = 0; i < 20 * DIV; i++) expq[d].push_back(mk(frame[i / DIV], 1'b0, 1'b1, 1'b0, 1'b0));
        end
        expq[d].push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                expq[d].delete();
                cur[d] = IDLE_E;
            end else begin
                if (cur[d].ready && dv_a[d]) build(d, data_a[d]);
                cur[d] = expq[d].size() > 0 ? expq[d].pop_front() : IDLE_E;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e = rst ? cur[d] : IDLE_E;
            check($sformatf("outs dut%0d cyc%0d", d, cyc),
                  {28'h0, tx_a[d], rdy_a[d], busy_a[d] & ~e.bx, done_a[d]},
                  {28'h0, e.tx, e.ready, e.busy & ~e.bx, e.done});
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) rx_act[d] = 1'b0;
            else if (!rx_act[d]) begin
                if (!tx_a[d]) begin
                    rx_act[d] = 1'b1;
                    rx_t[d]   = 0;
                end
            end else rx_t[d]++;
            if (rx_act[d] && rx_t[d] % DIV == DIV / 2) begin
                if (d == 0) bitsq.push_back(tx_a[d]);
                if (rx_t[d] / DIV >= 1 && rx_t[d] / DIV <= 8) rx_sh[d][3'(rx_t[d] / DIV - 1)] = tx_a[d];
                if (rx_t[d] / DIV == 9) begin
                    if (tx_a[d]) rxq[d].push_back(rx_sh[d]);
                    rx_act[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && dv_a[0] && rdy_a[0]) acc_t.push_back(cyc);
        if (rst && !in_word && tx_prev && !tx_a[0]) begin
            fall_t.push_back(cyc);
            in_word = 1'b1;
        end
        if (rst && done_a[0]) done_t.push_back(cyc);
        if (!rst || done_a[0]) in_word = 1'b0;
        tx_prev = tx_a[0];
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        fall_t.delete();
        done_t.delete();
        acc_t.delete();
        bitsq.delete();
        rxq[0].delete();
        rxq[1].delete();
    endtask

    function automatic int at(int q[$], int i);
        return i < q.size() ? q[i] : -100000;
    endfunction

    function automatic logic [15:0] rx_word(int d, int i);
        return 2 * i + 1 < rxq[d].size() ? {rxq[d][2 * i], rxq[d][2 * i + 1]} : 16'hxxxx;
    endfunction

    function automatic logic [19:0] pack_bits();
        logic [19:0] v = 20'hxxxxx;
        for (int i = 0; i < 20 && i < bitsq.size(); i++) v[19 - i] = bitsq[i];
        return v;
    endfunction

    function automatic logic [15:0] mux_word(int t);
        logic [3:0] g = 4'(t);
        return {g, {g, g, g} ^ 12'h5A5};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur[d]    = IDLE_E;
            rx_act[d] = 1'b0;
            rx_t[d]   = 0;
            rx_sh[d]  = 8'h0;
            data_a[d] = 16'h0;
            dv_a[d]   = 1'b0;
        end
        dv_a[0]   = 1'b1;
        data_a[0] = 16'h1A5C;
        tick(5);
        check("reset outs", {tx_a[0], rdy_a[0], busy_a[0], done_a[0]}, 4'b1100);
        dv_a[0] = 1'b0;
        rst     = 1'b1;
        tick(3);
        check("reset no accept", acc_t.size() + fall_t.size() + done_t.size(), 0);

        clear();
        data_a[0] = 16'h1A5C;
        dv_a[0]   = 1'b1;
        tick(1);
        dv_a[0]   = 1'b0;
        data_a[0] = 16'hFFFF;
        tick(210);
        check("single byte count", rxq[0].size(), 2);
        check("single word", rx_word(0, 0), 16'h1A5C);
        check("single bitstream", pack_bits(), 20'b0010110001_0001110101);
        check("single done count", done_t.size(), 1);
        check("single done cycle", at(done_t, 0) - at(fall_t, 0) + 1, 201);

        clear();
        data_a[0] = 16'h2123;
        dv_a[0]   = 1'b1;
        tick(1);
        data_a[0] = 16'h3456;
        tick(202);
        dv_a[0]   = 1'b0;
        data_a[0] = 16'hBEEF;
        tick(210);
        check("b2b spacing", at(fall_t, 1) - at(fall_t, 0), 202);
        check("b2b word0", rx_word(0, 0), 16'h2123);
        check("b2b word1", rx_word(0, 1), 16'h3456);
        check("b2b done count", done_t.size(), 2);

        clear();
        data_a[0] = 16'h0FFF;
        dv_a[0]   = 1'b1;
        tick(1);
        dv_a[0] = 1'b0;
        tick(6);
        check("drop tx quiet", fall_t.size(), 0);
        check("drop done count", done_t.size(), 1);
        check("drop done delay", at(done_t, 0) - at(acc_t, 0), 2);
        data_a[1] = 16'h0FFF;
        dv_a[1]   = 1'b1;
        tick(1);
        dv_a[1] = 1'b0;
        tick(210);
        check("nodrop word", rx_word(1, 0), 16'h0FFF);

        clear();
        data_a[0] = 16'hC3A5;
        dv_a[0]   = 1'b1;
        tick(1);
        dv_a[0] = 1'b0;
        tick(42);
        check("bit3 low before reset", tx_a[0], 1'b0);
        rst = 1'b0;
        #1;
        check("reset mid tx busy", {tx_a[0], busy_a[0]}, 2'b10);
        tick(3);
        rst = 1'b1;
        tick(3);
        check("reset mid no done", done_t.size(), 0);
        clear();
        data_a[0] = 16'h7001;
        dv_a[0]   = 1'b1;
        tick(1);
        dv_a[0] = 1'b0;
        tick(210);
        check("after reset count", rxq[0].size(), 2);
        check("after reset word", rx_word(0, 0), 16'h7001);

        clear();
        tag       = 1;
        data_a[0] = mux_word(1);
        dv_a[0]   = 1'b1;
        for (int n = 0; n < 7 * 210 && tag <= 7; n++) begin
            @(negedge clk);
            adv = done_a[0];
            @(posedge clk);
            #1;
            if (adv) tag++;
            if (tag > 7) dv_a[0] = 1'b0;
            else data_a[0] = mux_word(tag);
        end
        dv_a[0] = 1'b0;
        tick(5);
        check("mux loop finished", tag, 8);
        check("mux byte count", rxq[0].size(), 14);
        for (int i = 0; i < 7; i++) check($sformatf("mux word %0d", i + 1), rx_word(0, i), mux_word(i + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
